// File: rtl/bus_master_port_if.sv
// Serial bus signals between one master port and the bus mux/arbiter.
//   master modport : drives request/select/frame bits, receives grant and slave response
//   slave modport  : the arbiter/slave side view of the same wires
interface bus_master_port_if;
    logic m_request;
    logic m_slave_sel;
    logic m_grant;
    logic m_valid;
    logic m_rw;
    logic m_wbit;
    logic s_rbit;
    logic s_rvalid;
    logic s_ready;

    modport master (
        output m_request, m_slave_sel, m_valid, m_rw, m_wbit,
        input  m_grant, s_rbit, s_rvalid, s_ready
    );

    modport slave (
        input  m_request, m_slave_sel, m_valid, m_rw, m_wbit,
        output m_grant, s_rbit, s_rvalid, s_ready
    );
endinterface

// File: rtl/bus_master_port.sv
// Master-side serial bus port: latches one host command, requests the bus,
// serialises the slave select, shifts address/write data out or collects read
// data, then reports completion with an error flag.
//
// Ports:
//   sys_clk, sys_rst       clock, synchronous active-low reset
//   start/rw/slave_id/addr/wdata   host command (accepted only while idle)
//   busy/done/err/rdata    host status and read result
//   bus                    serial bus signals (master modport)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for host start
// SEL0       | request raised, slave_id[0] on m_slave_sel
// SEL1       | request raised, slave_id[1] on m_slave_sel
// WAIT_GRANT | waiting for arbiter grant, timeout running
// ADDR       | shifting address out LSB first
// WDATA      | shifting write data out LSB first
// WAIT_RESP  | waiting for write ack or collecting read bits
// FINISH     | one-cycle done pulse, err valid
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  rw,
    input  logic [1:0]            slave_id,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    bus_master_port_if.master     bus
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_WIDTH - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SEL0, SEL1, WAIT_GRANT, ADDR, WDATA, WAIT_RESP, FINISH
    } state_t;

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic [1:0]            sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [TW-1:0]         to_q, to_d;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            bit_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            bit_q   <= bit_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        logic resp_done;
        state_d   = state_q;
        rw_d      = rw_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        bit_d     = bit_q;
        to_d      = to_q;
        resp_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    sel_d   = slave_id;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    bit_d   = '0;
                    to_d    = '0;
                    if (slave_id == 2'd0) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = SEL0;
                    end
                end
            end
            SEL0: state_d = SEL1;
            SEL1: begin
                to_d    = '0;
                state_d = WAIT_GRANT;
            end
            WAIT_GRANT: begin
                if (bus.m_grant) begin
                    bit_d   = '0;
                    state_d = ADDR;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ADDR: begin
                // grant low is a split: hold everything until it returns
                if (bus.m_grant) begin
                    addr_d = addr_q >> 1;
                    if (bit_q == ADDR_LAST) begin
                        bit_d = '0;
                        if (rw_q) begin
                            state_d = WDATA;
                        end else begin
                            to_d    = '0;
                            state_d = WAIT_RESP;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            WDATA: begin
                if (bus.m_grant) begin
                    wdata_d = wdata_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        to_d    = '0;
                        state_d = WAIT_RESP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            WAIT_RESP: begin
                if (bus.m_grant) begin
                    if (rw_q) begin
                        resp_done = bus.s_ready;
                    end else if (bus.s_rvalid) begin
                        // LSB arrives first, so shift in from the top
                        rx_d = {bus.s_rbit, rx_q[DATA_WIDTH-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d     = '0;
                            rdata_d   = rx_d;
                            resp_done = 1'b1;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                    // a response in the same cycle as the timeout wins
                    if (resp_done) begin
                        state_d = FINISH;
                    end else if (to_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state_q != IDLE);
        done            = (state_q == FINISH);
        err             = (state_q == FINISH) && err_q;
        rdata           = rdata_q;

        bus.m_request   = (state_q == SEL0) || (state_q == SEL1) ||
                          (state_q == WAIT_GRANT) || (state_q == ADDR) ||
                          (state_q == WDATA) || (state_q == WAIT_RESP);
        bus.m_slave_sel = 1'b0;
        if (state_q == SEL0) bus.m_slave_sel = sel_q[0];
        if (state_q == SEL1) bus.m_slave_sel = sel_q[1];

        bus.m_valid     = ((state_q == ADDR) || (state_q == WDATA)) && bus.m_grant;
        bus.m_rw        = rw_q && ((state_q == ADDR) || (state_q == WDATA) ||
                                   (state_q == WAIT_RESP));
        bus.m_wbit      = 1'b0;
        if (bus.m_valid) begin
            bus.m_wbit = (state_q == ADDR) ? addr_q[0] : wdata_q[0];
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;

    logic        clk;
    logic        sys_rst;
    logic        start;
    logic        rw;
    logic [1:0]  slave_id;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rdata;

    int n_tests = 0;
    int n_fail  = 0;

    bus_master_port_if bus();

    bus_master_port #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .TIMEOUT   (16)
    ) dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .start   (start),
        .rw      (rw),
        .slave_id(slave_id),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {busy, done, err, bus.m_request, bus.m_slave_sel,
                bus.m_valid, bus.m_rw, bus.m_wbit, rdata};
    endfunction

    logic [19:0] frame;
    logic [9:0]  rv_tab, rb_tab, gr_tab;
    logic [7:0]  dv;
    logic [11:0] sa;
    int nval, nbad, nhold;
    logic resume_bit;

    initial begin
        sys_rst      = 1'b0;
        start        = 1'b1;
        rw           = 1'b1;
        slave_id     = 2'd1;
        addr         = 12'hFFF;
        wdata        = 8'hFF;
        bus.m_grant  = 1'b0;
        bus.s_rbit   = 1'b0;
        bus.s_rvalid = 1'b0;
        bus.s_ready  = 1'b0;

        // reset with start held high
        repeat (2) @(negedge clk);
        #1 chk("rst_outs", all_outs(), 32'h0);
        sys_rst = 1'b1;
        start   = 1'b0;
        @(negedge clk); #1;
        chk("rst_idle", {busy, bus.m_request}, 2'b00);

        // write, slave 2
        @(negedge clk);
        start = 1'b1; rw = 1'b1; slave_id = 2'd2; addr = 12'hA5C; wdata = 8'h3C;
        #1 chk("wr_idle_busy", busy, 1'b0);
        @(negedge clk); start = 1'b0; #1;
        chk("wr_sel0", {busy, bus.m_request, bus.m_slave_sel}, 3'b110);
        @(negedge clk); #1;
        chk("wr_sel1", {bus.m_request, bus.m_slave_sel}, 2'b11);
        @(negedge clk); bus.m_grant = 1'b1; #1;
        chk("wr_wg", {bus.m_request, bus.m_slave_sel, bus.m_valid}, 3'b100);
        frame = '0; nval = 0; nbad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.m_valid) begin
                frame[nval] = bus.m_wbit;
                nval++;
                if (bus.m_rw !== 1'b1) nbad++;
            end
        end
        chk("wr_nvalid", nval, 20);
        chk("wr_frame", frame, {8'h3C, 12'hA5C});
        chk("wr_m_rw", nbad, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("wr_resp_wait", {bus.m_valid, bus.m_request, done}, 3'b010);
        end
        @(negedge clk); bus.s_ready = 1'b1; #1;
        chk("wr_ack_cycle", done, 1'b0);
        @(negedge clk); bus.s_ready = 1'b0; #1;
        chk("wr_done", {done, err, bus.m_request}, 3'b100);
        @(negedge clk); #1;
        chk("wr_idle", {busy, done}, 2'b00);

        // read, slave 3, returns 0x96 with a gap and a split cycle
        rv_tab = 10'b1111110111;
        rb_tab = 10'b1001101110;
        gr_tab = 10'b1111011111;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; slave_id = 2'd3; addr = 12'h123;
        #1;
        @(negedge clk); #1;
        chk("rd_sel0", {bus.m_request, bus.m_slave_sel}, 2'b11);
        @(negedge clk); start = 1'b0; #1;
        chk("rd_sel1", {bus.m_request, bus.m_slave_sel}, 2'b11);
        @(negedge clk); #1;
        chk("rd_wg", {bus.m_request, bus.m_slave_sel}, 2'b10);
        frame = '0; nval = 0; nbad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (bus.m_valid) begin
                frame[nval] = bus.m_wbit;
                nval++;
                if (bus.m_rw !== 1'b0) nbad++;
            end
        end
        chk("rd_addr", {nval[7:0], frame[11:0]}, {8'd12, 12'h123});
        chk("rd_m_rw", nbad, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.s_rvalid = rv_tab[i];
            bus.s_rbit   = rb_tab[i];
            bus.m_grant  = gr_tab[i];
            #1;
            if (i == 9) chk("rd_rdata_hold", {done, rdata}, {1'b0, 8'h00});
        end
        @(negedge clk); bus.s_rvalid = 1'b0; #1;
        chk("rd_done", {done, err, rdata}, {2'b10, 8'h96});
        @(negedge clk); #1;
        chk("rd_idle", {busy, rdata}, {1'b0, 8'h96});

        // split during address phase
        sa = 12'h6B3;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; slave_id = 2'd1; addr = sa;
        #1;
        @(negedge clk); start = 1'b0; #1;
        chk("sp_sel0", bus.m_slave_sel, 1'b1);
        @(negedge clk); #1;
        chk("sp_sel1", bus.m_slave_sel, 1'b0);
        @(negedge clk); #1;
        frame = '0; nval = 0; nhold = 0; resume_bit = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.m_grant = (i < 7 || i >= 12);
            #1;
            if (bus.m_valid) begin
                frame[nval] = bus.m_wbit;
                nval++;
                if (i == 12) resume_bit = bus.m_wbit;
            end else if (bus.m_request) begin
                nhold++;
            end
        end
        chk("sp_nvalid", nval, 12);
        chk("sp_hold", nhold, 5);
        chk("sp_resume_bit7", resume_bit, sa[7]);
        chk("sp_addr", frame[11:0], sa);
        dv = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.s_rvalid = 1'b1;
            bus.s_rbit   = dv[i];
            #1;
        end
        @(negedge clk); bus.s_rvalid = 1'b0; #1;
        chk("sp_done", {done, err, rdata}, {2'b10, 8'h5A});

        // timeout waiting for grant
        @(negedge clk);
        bus.m_grant = 1'b0;
        start = 1'b1; rw = 1'b1; slave_id = 2'd1;
        #1;
        @(negedge clk); start = 1'b0; #1;
        @(negedge clk); #1;
        nbad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            if (done !== 1'b0 || bus.m_request !== 1'b1) nbad++;
        end
        chk("to_waiting", nbad, 0);
        @(negedge clk); #1;
        chk("to_done", {done, err, bus.m_request, rdata}, {3'b110, 8'h5A});
        @(negedge clk); #1;
        chk("to_idle", busy, 1'b0);

        // illegal slave id, plus start during FINISH
        @(negedge clk);
        start = 1'b1; rw = 1'b1; slave_id = 2'd0;
        #1 chk("il_noreq0", bus.m_request, 1'b0);
        @(negedge clk); slave_id = 2'd1; #1;
        chk("il_done", {done, err, bus.m_request}, 3'b110);
        @(negedge clk); start = 1'b0; #1;
        chk("il_start_in_finish", {busy, bus.m_request}, 2'b00);

        // reset mid write-data
        @(negedge clk);
        bus.m_grant = 1'b1;
        start = 1'b1; rw = 1'b1; slave_id = 2'd1; addr = 12'h0F0; wdata = 8'hFF;
        #1;
        @(negedge clk); start = 1'b0; #1;
        repeat (2 + 12 + 3) @(negedge clk);
        sys_rst = 1'b0;
        #1 chk("ab_in_wdata", {bus.m_valid, bus.m_rw, bus.m_wbit}, 3'b111);
        @(negedge clk); sys_rst = 1'b1; #1;
        chk("ab_outs", all_outs(), 32'h0);
        nbad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) nbad++;
        end
        chk("ab_no_done", nbad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
